// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for a shift-free add-and-decrement multiplier datapath.
// Strobes drive A/B/P registers; an iteration guard aborts runaway loops into ERR.
module mul_seq_ctrl #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] MAX_ITER = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_eqz,
    output logic             o_ldA,
    output logic             o_ldB,
    output logic             o_clrP,
    output logic             o_ldP,
    output logic             o_decB,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [WIDTH-1:0] o_iter
);

    // state    | meaning
    // S_IDLE   | waiting for start, all strobes low
    // S_LOAD_A | load multiplicand, clear iter/err
    // S_LOAD_B | load down-counter, clear product
    // S_ADD    | one P += A per cycle until counter is zero
    // S_DONE   | one-cycle completion pulse
    // S_ERR    | iteration guard tripped, err latched
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_ADD,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state;
    logic             r_ldA;
    logic             r_ldB;
    logic             r_clrP;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_iter;

    logic             w_guard;
    logic             w_add;
    logic             w_kill;

    always_comb begin
        w_guard = (r_iter == MAX_ITER);
        w_kill  = i_abort && (r_state != S_IDLE);
        w_add   = (r_state == S_ADD) && !i_abort && !i_eqz && !w_guard;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ldA   <= 1'b0;
            r_ldB   <= 1'b0;
            r_clrP  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_iter  <= '0;
        end else begin
            r_ldA  <= 1'b0;
            r_ldB  <= 1'b0;
            r_clrP <= 1'b0;
            r_done <= 1'b0;
            if (w_add) begin
                r_iter <= r_iter + 1'b1;
            end
            if (w_kill) begin
                // abandon without touching err or iter
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_state <= S_LOAD_A;
                            r_ldA   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_LOAD_A: begin
                        r_iter  <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_LOAD_B;
                        r_ldB   <= 1'b1;
                        r_clrP  <= 1'b1;
                    end
                    S_LOAD_B: begin
                        r_state <= S_ADD;
                    end
                    S_ADD: begin
                        if (i_eqz) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_guard) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    S_DONE, S_ERR: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // abort silences the state-decoded strobes in the same cycle it is seen
    assign o_ldA  = r_ldA  && !w_kill;
    assign o_ldB  = r_ldB  && !w_kill;
    assign o_clrP = r_clrP && !w_kill;
    assign o_done = r_done && !w_kill;
    assign o_ldP  = w_add;
    assign o_decB = w_add;
    assign o_busy = r_busy;
    assign o_err  = r_err;
    assign o_iter = r_iter;

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: width of operand and iteration-count paths.
REQ-002 Parameter MAX_ITER, default 16'hFFFF: addition-count limit before error abort.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a multiplication; sampled only in IDLE.
REQ-006 abort  input  1  cancel the operation in progress; returns to IDLE.
REQ-007 eqz  input  1  datapath status: down-counter (multiplier B) value equals zero.
REQ-008 ldA  output  1  load multiplicand register A from the shared din bus.
REQ-009 ldB  output  1  load down-counter from din (counter load).
REQ-010 clrP  output  1  clear product register P.
REQ-011 ldP  output  1  P <= P + A.
REQ-012 decB  output  1  down-counter decrement (counter dec).
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 err  output  1  sticky: iteration guard tripped.
REQ-016 iter  output  WIDTH  number of ldP pulses issued for the current/last operation.

Function
REQ-017 The controller SHALL implement states IDLE, LOAD_A, LOAD_B, ADD, DONE, ERR.
REQ-018 IDLE: start=1 -> LOAD_A; otherwise stay; all strobes low.
REQ-019 LOAD_A: ldA=1 for exactly one cycle; iter cleared to 0 and err cleared at the end of this cycle; -> LOAD_B.
REQ-020 LOAD_B: ldB=1 and clrP=1 for exactly one cycle; -> ADD.
REQ-021 ADD: eqz=1 -> DONE with ldP=decB=0 in that cycle.
REQ-022 ADD: eqz=0 and iter<MAX_ITER -> ldP=decB=1 (same cycle), iter+1, stay in ADD.
REQ-023 ADD: eqz=0 and iter==MAX_ITER -> ERR with ldP=decB=0; eqz=1 has priority over the guard.
REQ-024 ldP/decB SHALL be combinational from state, eqz, abort and the guard compare; all other strobes decode state only.
REQ-025 DONE: done=1 one cycle; -> IDLE.
REQ-026 ERR: one cycle; err set at entry and held until the next LOAD_A; done stays 0; -> IDLE.
REQ-027 Latency: done asserted exactly B+4 cycles after the cycle start is sampled in IDLE (B = value loaded in LOAD_B).
REQ-028 start while busy SHALL be ignored (no queueing).
REQ-029 abort=1 in any busy state SHALL force all strobes low that cycle and -> IDLE next edge; done not pulsed, err unchanged, iter holds its value.
REQ-030 abort has priority over eqz and the guard; abort in IDLE has no effect.
REQ-031 iter SHALL not wrap: increment only when ldP=1.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, busy=done=err=0, iter=0, all strobes low, independent of clk.
REQ-033 Reset mid-operation SHALL abandon the operation; first start after rst release begins at LOAD_A.

Verification
REQ-034 A=5, B=3, start at cycle 0 -> ldA c1, ldB/clrP c2, ldP/decB c3-c5, DONE c7; iter=3, datapath P=15.
REQ-035 B=0 -> no ldP pulses, done at c4, iter=0, P=0.
REQ-036 MAX_ITER=4, B=10 -> ldP c3-c6, ERR at c8, err=1 held, done never pulses; next start clears err in LOAD_A.
REQ-037 B=6, abort high at c5 -> no strobes at c5, IDLE at c6, busy=0, iter=2, done=0.
REQ-038 start held high throughout operation with B=2 -> exactly one sequence until DONE, new sequence begins only after re-entering IDLE.
REQ-039 rst asserted mid-ADD (between clock edges) -> outputs reset immediately; subsequent A=2, B=2 completes with P=4, done at c6.
